// File: rtl/elink_txo_pkg.sv
// rtl/elink_txo_pkg.sv - shared types, frame codes and word encoders for the eLink TX framer
package elink_txo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } txn_t;

  localparam logic [7:0]  FRAME_IDLE = 8'h00;
  localparam logic [7:0]  FRAME_HDR  = 8'h3F;
  localparam logic [7:0]  FRAME_PAY  = 8'hFF;
  localparam logic [31:0] ADDR_INC   = 32'd8;

  function automatic logic is_dbl(input txn_t t);
    return t.write && (t.datamode == 2'b11) && (t.ctrlmode == 4'd0);
  endfunction

  function automatic logic [63:0] hdr_word(input txn_t t);
    logic [63:0] w;
    w        = '0;
    w[7:0]   = {t.dstaddr[3:0], t.datamode, t.write, 1'b1};
    w[15:8]  = t.dstaddr[11:4];
    w[23:16] = t.dstaddr[19:12];
    w[31:24] = t.dstaddr[27:20];
    w[39:32] = {t.ctrlmode, t.dstaddr[31:28]};
    w[47:40] = {~t.write, 7'b0};
    return w;
  endfunction

  // Each serdes lane carries one bit position of every byte: lane k bit j = word[8j+k].
  function automatic logic [63:0] lane_map(input logic [63:0] w);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        m[8*k+j] = w[8*j+k];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/elink_txo_fifo.sv
// rtl/elink_txo_fifo.sv - synchronous transaction FIFO with occupancy count
module elink_txo_fifo
  import elink_txo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  txn_t                   wr_data,
  output txn_t                   rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  txn_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/elink_txo_framer.sv
// rtl/elink_txo_framer.sv - emesh to serdes TX framer; burst merging compiled in by ELINK_TXO_BURST_EN
module elink_txo_framer
  import elink_txo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   txo_lclk,
  input  logic                   reset,
  input  logic                   txo_emesh_access,
  input  logic                   txo_emesh_write,
  input  logic [1:0]             txo_emesh_datamode,
  input  logic [3:0]             txo_emesh_ctrlmode,
  input  logic [31:0]            txo_emesh_dstaddr,
  input  logic [31:0]            txo_emesh_srcaddr,
  input  logic [31:0]            txo_emesh_data,
  input  logic                   burst_en,
  input  logic                   txo_rd_wait,
  output logic                   txo_emesh_wait,
  output logic [$clog2(DEPTH):0] txo_fifo_count,
  output logic [71:0]            tx_in
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t state;
  state_t state_next;
  txn_t   in_txn;
  txn_t   head;
  txn_t   cur;
  logic   head_valid;
  logic   push;
  logic   pop;

  assign in_txn = '{write:    txo_emesh_write,
                    datamode: txo_emesh_datamode,
                    ctrlmode: txo_emesh_ctrlmode,
                    dstaddr:  txo_emesh_dstaddr,
                    srcaddr:  txo_emesh_srcaddr,
                    data:     txo_emesh_data};

  assign txo_emesh_wait = (txo_fifo_count == CW'(DEPTH));
  assign push           = txo_emesh_access && !txo_emesh_wait;
  assign head_valid     = (txo_fifo_count != '0);

  elink_txo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (txo_lclk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_txn),
    .rd_data (head),
    .count   (txo_fifo_count)
  );

`ifdef ELINK_TXO_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] beats;
  logic          burst_ok;

  assign burst_ok = burst_en && !txo_rd_wait && head_valid &&
                    is_dbl(cur) && is_dbl(head) &&
                    (head.dstaddr == cur.dstaddr + ADDR_INC) &&
                    (beats < BW'(MAX_BURST));

  always_ff @(posedge txo_lclk) begin
    if (reset) begin
      beats <= '0;
    end else if (state == ST_HDR) begin
      beats <= BW'(1);
    end else if ((state == ST_PAY) && burst_ok) begin
      beats <= beats + BW'(1);
    end
  end
`else
  localparam int unused_max_burst = MAX_BURST;
  logic          unused_burst_en;
  assign unused_burst_en = burst_en;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (head_valid && !txo_rd_wait) begin
          pop        = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_HDR: state_next = ST_PAY;
      ST_PAY: begin
        state_next = ST_IDLE;
`ifdef ELINK_TXO_BURST_EN
        if (burst_ok) begin
          pop        = 1'b1;
          state_next = ST_PAY;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge txo_lclk) begin
    if (reset) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      state <= state_next;
      if (pop) cur <= head;
    end
  end

  // tx_in is a pure function of the registered state and cur, one cycle behind them.
  always_ff @(posedge txo_lclk) begin
    if (reset) begin
      tx_in <= '0;
    end else begin
      case (state)
        ST_HDR:  tx_in <= {FRAME_HDR, lane_map(hdr_word(cur))};
        ST_PAY:  tx_in <= {FRAME_PAY, lane_map({cur.data, cur.srcaddr})};
        default: tx_in <= {FRAME_IDLE, 64'd0};
      endcase
    end
  end

endmodule

// File: tb/tb_elink_txo_framer.sv
// tb/tb_elink_txo_framer.sv - scoreboard bench for elink_txo_framer (DEPTH 4, MAX_BURST 2)
module tb_elink_txo_framer;
  import elink_txo_pkg::*;

  localparam int DP = 4;
  localparam int MB = 2;
`ifdef ELINK_TXO_BURST_EN
  localparam bit BURST_BUILD = 1'b1;
`else
  localparam bit BURST_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        access = 1'b0;
  logic        write_s = 1'b0;
  logic [1:0]  datamode = '0;
  logic [3:0]  ctrlmode = '0;
  logic [31:0] dstaddr = '0;
  logic [31:0] srcaddr = '0;
  logic [31:0] data = '0;
  logic        burst_en = 1'b1;
  logic        rd_wait = 1'b0;
  logic        wait_s;
  logic [$clog2(DP):0] count;
  logic [71:0] tx_in;

  int n_checks = 0;
  int n_fail = 0;

  txn_t       exp_q[$];
  logic [7:0] flog[$];
  logic [7:0] eseq[$];
  logic       log_en = 1'b0;

  elink_txo_framer #(.DEPTH(DP), .MAX_BURST(MB)) dut (
    .txo_lclk           (clk),
    .reset              (reset),
    .txo_emesh_access   (access),
    .txo_emesh_write    (write_s),
    .txo_emesh_datamode (datamode),
    .txo_emesh_ctrlmode (ctrlmode),
    .txo_emesh_dstaddr  (dstaddr),
    .txo_emesh_srcaddr  (srcaddr),
    .txo_emesh_data     (data),
    .burst_en           (burst_en),
    .txo_rd_wait        (rd_wait),
    .txo_emesh_wait     (wait_s),
    .txo_fifo_count     (count),
    .tx_in              (tx_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encodings written from the field rules as plain arithmetic.
  function automatic logic [63:0] m_hdr(input txn_t t);
    return 64'd1 | (64'(t.write) << 1) | (64'(t.datamode) << 2) | (64'(t.dstaddr) << 4) |
           (64'(t.ctrlmode) << 36) | (64'(!t.write) << 47);
  endfunction

  function automatic logic [63:0] m_pay(input txn_t t);
    return {t.data, t.srcaddr};
  endfunction

  function automatic bit m_dbl(input txn_t t);
    return (t.write == 1'b1) && (t.datamode == 2'b11) && (t.ctrlmode == 4'd0);
  endfunction

  function automatic logic [63:0] unlane(input logic [71:0] v);
    logic [63:0] w;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++)
        w[8*j+k] = v[8*k+j];
    return w;
  endfunction

  function automatic txn_t mk(input logic w, input logic [1:0] dm, input logic [3:0] cm,
                              input logic [31:0] dst);
    txn_t t;
    t.write = w; t.datamode = dm; t.ctrlmode = cm; t.dstaddr = dst;
    t.srcaddr = $urandom; t.data = $urandom;
    return t;
  endfunction

  function automatic txn_t rand_txn(input txn_t p);
    txn_t t;
    if ($urandom_range(0, 1) == 1) begin
      t = mk(1'b1, 2'b11, 4'd0, p.dstaddr + 32'd8);
    end else begin
      t = mk(1'($urandom_range(0, 1)), 2'($urandom), 4'd0, $urandom);
      if ($urandom_range(0, 3) == 0) t.ctrlmode = 4'($urandom);
    end
    return t;
  endfunction

  // Monitor: every non-idle beat is matched against the next transaction in the scoreboard.
  logic [7:0] prev_frame = 8'h00;
  txn_t       cur_t;
  int         beats = 0;

  always @(negedge clk) begin
    logic [7:0]  frame;
    logic [63:0] word;
    txn_t        nt;
    bit          legal;
    if (reset) begin
      prev_frame = 8'h00;
    end else begin
      frame = tx_in[71:64];
      word  = unlane(tx_in);
      if (log_en) flog.push_back(frame);
      case (frame)
        8'h00: begin
          chk("idle_word", word, 64'd0);
          if (prev_frame == 8'h3F) chk("hdr_then_pay", 64'(frame), 64'hFF);
        end
        8'h3F: begin
          chk("hdr_after_idle", 64'(prev_frame), 64'h00);
          if (exp_q.size() == 0) begin
            chk("hdr_unexpected", 64'd1, 64'd0);
          end else begin
            cur_t = exp_q.pop_front();
            chk("hdr_word", word, m_hdr(cur_t));
          end
          beats = 0;
        end
        8'hFF: begin
          if (prev_frame == 8'h3F) begin
            beats = 1;
            chk("payload", word, m_pay(cur_t));
          end else if (prev_frame == 8'hFF) begin
            if (exp_q.size() == 0) begin
              chk("burst_unexpected", 64'd1, 64'd0);
            end else begin
              nt = exp_q.pop_front();
              legal = BURST_BUILD && burst_en && m_dbl(cur_t) && m_dbl(nt) &&
                      (nt.dstaddr == cur_t.dstaddr + 32'd8) && (beats < MB);
              chk("burst_legal", 64'(legal), 64'd1);
              chk("burst_payload", word, m_pay(nt));
              cur_t = nt;
              beats++;
            end
          end else begin
            chk("pay_without_hdr", 64'(prev_frame), 64'h3F);
          end
        end
        default: chk("frame_code", 64'(frame), 64'h00);
      endcase
      prev_frame = frame;
    end
  end

  task automatic push(input txn_t t);
    int g = 0;
    @(negedge clk);
    access = 1'b1; write_s = t.write; datamode = t.datamode; ctrlmode = t.ctrlmode;
    dstaddr = t.dstaddr; srcaddr = t.srcaddr; data = t.data;
    while (wait_s && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) begin
      chk("push_timeout", 64'd1, 64'd0);
      access = 1'b0;
    end else begin
      exp_q.push_back(t);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    access = 1'b0;
  endtask

  task automatic add_grp(input int n);
    eseq.push_back(8'h3F);
    repeat (n) eseq.push_back(8'hFF);
    eseq.push_back(8'h00);
  endtask

  task automatic run_prefilled(input string tag, input bit from_full);
    logic [7:0] b;
    flog.delete();
    log_en = 1'b1;
    @(negedge clk);
    rd_wait = 1'b0;
    @(negedge clk);
    if (from_full) begin
      chk({tag, "_count_after_pop"}, 64'(count), 64'd3);
      chk({tag, "_wait_fall"}, 64'(wait_s), 64'd0);
    end
    repeat (20) @(negedge clk);
    log_en = 1'b0;
    while (flog.size() > 0 && flog[0] == 8'h00) b = flog.pop_front();
    for (int i = 0; i < eseq.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i), (i < flog.size()) ? 64'(flog[i]) : 64'h1FF,
          64'(eseq[i]));
    eseq.delete();
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin @(negedge clk); g++; end
    repeat (5) @(negedge clk);
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    txn_t p;
    int   g;
    int   nz;
    bit   rand_done;

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_in", tx_in[63:0], 64'd0);
    chk("rst_frame", 64'(tx_in[71:64]), 64'd0);
    chk("rst_wait", 64'(wait_s), 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // Single write: latency header/payload/idle
    t = mk(1'b1, 2'b10, 4'd0, 32'h8080_0010);
    t.data = 32'hDEADBEEF; t.srcaddr = 32'h1234_5678;
    push(t);
    idle();
    @(negedge clk);
    chk("lat_pre_hdr", 64'(tx_in[71:64]), 64'h00);
    @(negedge clk);
    chk("lat_hdr_frame", 64'(tx_in[71:64]), 64'h3F);
    chk("lat_hdr_word", unlane(tx_in), m_hdr(t));
    @(negedge clk);
    chk("lat_pay_frame", 64'(tx_in[71:64]), 64'hFF);
    chk("lat_pay_word", unlane(tx_in), 64'hDEADBEEF_12345678);
    @(negedge clk);
    chk("lat_idle", 64'(tx_in[71:64]), 64'h00);
    chk("lat_idle_word", tx_in[63:0], 64'd0);

    // Sequential double writes, capped at MB beats per header
    rd_wait = 1'b1;
    for (int i = 0; i < 4; i++) push(mk(1'b1, 2'b11, 4'd0, 32'h100 + 32'(8 * i)));
    idle();
    chk("full_wait_rise", 64'(wait_s), 64'd1);
    chk("full_count", 64'(count), 64'd4);
    if (BURST_BUILD) begin add_grp(2); add_grp(2); end
    else begin add_grp(1); add_grp(1); add_grp(1); add_grp(1); end
    run_prefilled("burst", 1'b1);

    // Non-sequential double writes
    rd_wait = 1'b1;
    push(mk(1'b1, 2'b11, 4'd0, 32'h100));
    push(mk(1'b1, 2'b11, 4'd0, 32'h200));
    idle();
    add_grp(1); add_grp(1);
    run_prefilled("nonseq", 1'b0);

    // Address increment across 2^32
    rd_wait = 1'b1;
    push(mk(1'b1, 2'b11, 4'd0, 32'hFFFF_FFF8));
    push(mk(1'b1, 2'b11, 4'd0, 32'h0000_0000));
    idle();
    if (BURST_BUILD) add_grp(2);
    else begin add_grp(1); add_grp(1); end
    run_prefilled("wrap", 1'b0);

    // Runtime burst disable
    burst_en = 1'b0;
    rd_wait = 1'b1;
    push(mk(1'b1, 2'b11, 4'd0, 32'h300));
    push(mk(1'b1, 2'b11, 4'd0, 32'h308));
    idle();
    add_grp(1); add_grp(1);
    run_prefilled("nobursten", 1'b0);
    burst_en = 1'b1;

    // Six pushes into a DEPTH-4 FIFO held by remote wait
    rd_wait = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) push(mk(1'b1, 2'b10, 4'd0, $urandom));
        idle();
      end
      begin
        g = 0;
        @(negedge clk);
        while (count != 3'(DP) && g < 100) begin @(negedge clk); g++; end
        chk("six_fill", 64'(g < 100), 64'd1);
        chk("six_wait_rise", 64'(wait_s), 64'd1);
        repeat (4) @(negedge clk);
        chk("six_held_count", 64'(count), 64'd4);
        chk("six_held_wait", 64'(wait_s), 64'd1);
        rd_wait = 1'b0;
      end
    join
    drain("six");

    // Reset while in PAY discards everything
    rd_wait = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(1'b1, 2'b10, 4'd0, $urandom));
    idle();
    @(negedge clk);
    rd_wait = 1'b0;
    g = 0;
    while (tx_in[71:64] != 8'h3F && g < 20) begin @(negedge clk); g++; end
    chk("rst_reach_pay", 64'(g < 20), 64'd1);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rstpay_tx_in", tx_in[63:0], 64'd0);
    chk("rstpay_frame", 64'(tx_in[71:64]), 64'd0);
    chk("rstpay_wait", 64'(wait_s), 64'd0);
    chk("rstpay_count", 64'(count), 64'd0);
    #1 reset = 1'b0;
    nz = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_in != '0) nz++;
    end
    chk("rstpay_quiet", 64'(nz), 64'd0);

    // Randomized traffic with random remote wait
    p = mk(1'b1, 2'b11, 4'd0, 32'h1000);
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          t = rand_txn(p);
          push(t);
          p = t;
          g = $urandom_range(0, 2);
          if (g > 0) repeat (g) idle();
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          rd_wait = ($urandom_range(0, 3) == 0);
        end
        rd_wait = 1'b0;
      end
    join
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
